// File: rtl/shoelace_loop_tester_if.sv
// Handshake/status bundle between a loop-tester controller and the tester core.
// The master side issues start/abort/enables and carries the echo nets back in.
// The slave side drives the loop nets and reports run status and statistics.
interface shoelace_loop_tester_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int LAT_W    = 8
);
    logic                      start;
    logic                      abort;
    logic [CHANNELS-1:0]       chan_en;
    logic [CHANNELS-1:0]       loop_out;
    logic [CHANNELS-1:0]       loop_in;
    logic                      busy;
    logic                      done;
    logic [CHANNELS-1:0]       err_timeout;
    logic [CHANNELS-1:0]       err_glitch;
    logic [CHANNELS*CNT_W-1:0] trip_count;
    logic [CHANNELS*LAT_W-1:0] lat_last;
    logic [LAT_W-1:0]          lat_max;

    modport master (
        output start, abort, chan_en, loop_in,
        input  loop_out, busy, done, err_timeout, err_glitch,
               trip_count, lat_last, lat_max
    );

    modport slave (
        input  start, abort, chan_en, loop_in,
        output loop_out, busy, done, err_timeout, err_glitch,
               trip_count, lat_last, lat_max
    );
endinterface

// File: rtl/shoelace_loop_tester.sv
// Multi-channel round-trip tester for co-simulated inverter loops.
// Each channel toggles its drive net, waits for the synchronised echo of the
// expected polarity, records latency and trip counts, and flags timeouts and
// echo transitions seen while no edge is in flight.
module shoelace_loop_tester #(
    parameter int CHANNELS = 4,
    parameter int STAGES   = 5,
    parameter int ITER     = 8,
    parameter int TIMEOUT  = 64,
    parameter int GAP      = 2,
    parameter int CNT_W    = 16,
    parameter int LAT_W    = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    shoelace_loop_tester_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_HALT} state_t;

    localparam bit               PARITY   = (STAGES % 2) == 1;
    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] ITER_C   = CNT_W'(ITER);
    localparam logic [LAT_W-1:0] LAT_SAT  = '1;

    state_t              state_q   [CHANNELS];
    state_t              state_d   [CHANNELS];
    logic [LAT_W-1:0]    lat_cnt_q [CHANNELS];
    logic [LAT_W-1:0]    lat_now   [CHANNELS];
    logic [GAP_W-1:0]    gap_cnt_q [CHANNELS];
    logic [CNT_W-1:0]    trip_q    [CHANNELS];
    logic [LAT_W-1:0]    lat_last_q[CHANNELS];
    logic [CHANNELS-1:0] sync1_q, sync2_q, exp_in;
    logic [CHANNELS-1:0] loop_out_q, err_to_q, err_gl_q;
    logic [CHANNELS-1:0] launch, match, expire, glitch;
    logic [LAT_W-1:0]    lat_max_q, lat_max_d;
    logic                busy_q, done_q, all_halt, run_start, run_end;

    assign exp_in    = loop_out_q ^ {CHANNELS{PARITY}};
    assign run_start = bus.start && !bus.abort && !busy_q;
    assign run_end   = busy_q && all_halt && !bus.abort;

    // Two-flop synchroniser on every echo net; only sync2_q is used downstream.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.loop_in;
            sync2_q <= sync1_q;
        end
    end

    // Run ends once every channel has parked in HALT.
    always_comb begin
        all_halt = 1'b1;
        for (int i = 0; i < CHANNELS; i++)
            if (state_q[i] != S_HALT) all_halt = 1'b0;
    end

    // Latency reported for a match on this edge, saturating at the field maximum.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            lat_now[i] = (lat_cnt_q[i] == LAT_SAT) ? LAT_SAT : lat_cnt_q[i] + LAT_W'(1);
    end

    // Per-channel next-state logic and event strobes.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        launch = '0;
        match  = '0;
        expire = '0;
        glitch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            if (bus.abort) begin
                state_d[i] = S_IDLE;
            end else begin
                unique case (state_q[i])
                    S_IDLE: begin
                        if (run_start) state_d[i] = bus.chan_en[i] ? S_LAUNCH : S_HALT;
                    end
                    S_LAUNCH: begin
                        launch[i]  = 1'b1;
                        state_d[i] = S_WAIT;
                    end
                    S_WAIT: begin
                        if (sync2_q[i] == exp_in[i]) begin
                            match[i] = 1'b1;
                            if (trip_q[i] + CNT_W'(1) == ITER_C) state_d[i] = S_HALT;
                            else if (GAP == 0)                   state_d[i] = S_LAUNCH;
                            else                                 state_d[i] = S_GAP;
                        end else if (int'(lat_cnt_q[i]) >= TIMEOUT - 1) begin
                            expire[i]  = 1'b1;
                            state_d[i] = S_HALT;
                        end
                    end
                    S_GAP: begin
                        glitch[i] = sync2_q[i] != exp_in[i];
                        if (gap_cnt_q[i] == GAP_LAST) state_d[i] = S_LAUNCH;
                    end
                    S_HALT: begin
                        glitch[i] = busy_q && (sync2_q[i] != exp_in[i]);
                        if (run_end) state_d[i] = S_IDLE;
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end
        end
    end

    // Run-wide maximum: the largest latency completing on this edge wins.
    always_comb begin
        lat_max_d = lat_max_q;
        for (int i = 0; i < CHANNELS; i++)
            if (match[i] && lat_now[i] > lat_max_d) lat_max_d = lat_now[i];
    end

    // Per-channel FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!rst_n) state_q[i] <= S_IDLE;
            else        state_q[i] <= state_d[i];
        end
    end

    // Per-channel datapath: drive net, latency/gap counters, statistics, sticky errors.
    // NOTE: the small per-channel arrays are reset because they feed outputs with defined reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!rst_n) begin
                loop_out_q[i] <= 1'b0;
                lat_cnt_q[i]  <= '0;
                gap_cnt_q[i]  <= '0;
                trip_q[i]     <= '0;
                lat_last_q[i] <= '0;
                err_to_q[i]   <= 1'b0;
                err_gl_q[i]   <= 1'b0;
            end else begin
                if (launch[i]) begin
                    loop_out_q[i] <= ~loop_out_q[i];
                    lat_cnt_q[i]  <= '0;
                end else if (state_q[i] == S_WAIT) begin
                    lat_cnt_q[i] <= lat_now[i];
                end
                gap_cnt_q[i] <= (state_q[i] == S_GAP) ? gap_cnt_q[i] + GAP_W'(1) : '0;
                if (run_start) begin
                    trip_q[i]     <= '0;
                    lat_last_q[i] <= '0;
                    err_to_q[i]   <= 1'b0;
                    err_gl_q[i]   <= 1'b0;
                end else begin
                    if (match[i]) begin
                        trip_q[i]     <= trip_q[i] + CNT_W'(1);
                        lat_last_q[i] <= lat_now[i];
                    end
                    if (expire[i]) err_to_q[i] <= 1'b1;
                    if (glitch[i]) err_gl_q[i] <= 1'b1;
                end
            end
        end
    end

    // Run control: busy spans start to all-halted, done marks a natural end only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lat_max_q <= '0;
        end else begin
            done_q    <= run_end;
            lat_max_q <= run_start ? '0 : lat_max_d;
            if (bus.abort)      busy_q <= 1'b0;
            else if (run_start) busy_q <= 1'b1;
            else if (run_end)   busy_q <= 1'b0;
        end
    end

    assign bus.loop_out    = loop_out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_to_q;
    assign bus.err_glitch  = err_gl_q;
    assign bus.lat_max     = lat_max_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign bus.trip_count[g*CNT_W +: CNT_W] = trip_q[g];
        assign bus.lat_last[g*LAT_W +: LAT_W]   = lat_last_q[g];
    end
endmodule

// File: doc/shoelace_loop_tester.md
# shoelace_loop_tester

Parametrised round-trip tester for co-simulation loops between the Verilog side and prsim. Each of CHANNELS independent channels toggles a drive net that is forwarded to prsim via `$to_prsim`, waits for the echo returned via `$from_prsim`, and checks its polarity against the loop's inversion count. It records per-channel round-trip latency, counts completed trips, and flags timeouts and spurious echo transitions. It replaces hand-written per-bench `always` display blocks for inverter-chain shoelace tests with a self-checking, multi-channel block.

## Interface
- CHANNELS, 4, number of independent loops
- STAGES, 5, inversions in each external loop; only bit 0 (parity) matters
- ITER, 8, round trips per channel per run
- TIMEOUT, 64, max latency in cycles before the timeout error
- GAP, 2, idle cycles between echo acceptance and next launch
- CNT_W, 16, trip counter width
- LAT_W, 8, latency field width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run on all enabled channels
- abort  in  1  one-cycle pulse; ends the run, channels return to IDLE
- chan_en  in  CHANNELS  channel enable, sampled at start
- loop_out  out  CHANNELS  drive nets toward prsim
- loop_in  in  CHANNELS  echo nets from prsim, asynchronous
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- err_timeout  out  CHANNELS  sticky per-channel timeout
- err_glitch  out  CHANNELS  sticky per-channel unexpected echo transition
- trip_count  out  CHANNELS*CNT_W  completed trips, channel i at [i*CNT_W +: CNT_W]
- lat_last  out  CHANNELS*LAT_W  latency of the most recent trip
- lat_max  out  LAT_W  maximum latency over all channels this run

## Operation
- Each loop_in bit passes through a 2-flop synchroniser before any use.
- Expected echo: exp_i = loop_out[i] ^ STAGES[0].
- Per-channel FSM states are IDLE, LAUNCH, WAIT, GAP, HALT.
- IDLE to LAUNCH: on start when chan_en[i]=1. Disabled channels go to HALT immediately.
- LAUNCH (1 cycle):
  - toggle loop_out[i]
  - clear the latency counter
  - go to WAIT
- WAIT:
  - the latency counter increments each cycle, saturating at 2^LAT_W-1
  - when sync_in equals exp_i, latch lat_last = counter+1 and increment trip_count (wraps at 2^CNT_W)
  - if trip_count reaches ITER, go to HALT; otherwise go to GAP
- WAIT timeout: if the launch edge plus TIMEOUT edges pass with no match, set err_timeout[i] and go to HALT.
- GAP: count GAP cycles, then go to LAUNCH. Any sync_in != exp_i in GAP or HALT while busy sets err_glitch[i]; the channel keeps running.
- Run end: busy=1 from the edge after start until all channels are in HALT. On that edge busy falls, done pulses for one cycle, and every FSM returns to IDLE.
- start while busy is ignored. A new start clears trip_count, lat_last, lat_max, err_timeout and err_glitch.
- abort forces all FSMs to IDLE and drops busy. done is not pulsed. Counters and errors hold their values.
- abort and start in the same cycle: abort wins.

## Timing
- Reset values:
  - loop_out = 0, so the idle echo level equals STAGES[0]
  - busy = 0, done = 0
  - err_* = 0
  - trip_count = 0, lat_last = 0, lat_max = 0
  - all FSMs in IDLE
- Reset mid-run takes effect immediately, asynchronously, with no done pulse.
- Zero-delay combinational loop gives a recorded latency of 3: the input changes after launch edge t0, is synchronised at t1 and t2, and is latched at t3.
- Minimum launch-to-launch period is latency + GAP + 1 cycles.
- lat_max updates on the same edge as lat_last. The largest channel wins when several channels complete on the same edge.

## Test plan
- CHANNELS=1, STAGES=5, ITER=8, loop_in = ~loop_out (combinational) -> 8 trips, every lat_last=3, lat_max=3, done pulses once, no errors.
- CHANNELS=4, per-channel delays of 0/2/5/10 cycles, STAGES=0 -> trip_count=8 on each channel, lat_last = 3/5/8/13, lat_max=13.
- Channel 2 with loop_in stuck, TIMEOUT=64 -> err_timeout=4'b0100 at launch+64, the other channels complete, done pulses.
- A single-cycle pulse injected on loop_in[1] during GAP -> err_glitch[1]=1, trip_count[1] still reaches ITER.
- abort after 3 trips -> busy falls the next cycle, no done pulse, trip_count=3 held. A following start clears the counters and runs a full 8 trips.
- rst_n asserted in WAIT -> all outputs take their reset values immediately, loop_out=0. chan_en=0 on all channels at start -> busy for exactly 1 cycle, then done.
